// File: rtl/sl_preceptron_pkg.sv
// Shared definitions for the sl_preceptron working-RAM block.
// Holds the controller state encoding and the default array geometry.
package sl_preceptron_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/sl_preceptron_wram_array.sv
// Storage array: one synchronous write port and one synchronous read port.
// A read and a write to the same address in the same cycle return the old word.
// Ports:
//   clk, rst        clock and synchronous active-high reset (read register only)
//   we, waddr, wdata write port
//   re, raddr       read request; rdata updates on the following edge
//   rdata           registered read data, held while re is low
module sl_preceptron_wram_array
  import sl_preceptron_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register; non-blocking update gives read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sl_preceptron_wram.sv
// Working RAM with single-word access, incrementing burst read and zero-fill.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_wen/mem_ren/mem_addr/mem_wdata  single-word access (IDLE only)
//   burst_start/burst_addr/burst_len    burst read of burst_len+1 words
//   clr_start                     zero-fill the whole array
//   out_ready/out_valid/out_data/out_last  read data stream
//   acc_ready                     a single read is accepted this cycle
//   busy                          BURST or CLEAR in progress
//   done                          completion pulse for burst or clear
module sl_preceptron_wram
  import sl_preceptron_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_wen,
  input  logic                  mem_ren,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  burst_start,
  input  logic [ADDR_WIDTH-1:0] burst_addr,
  input  logic [ADDR_WIDTH-1:0] burst_len,
  input  logic                  clr_start,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  acc_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  out_burst_q, out_burst_d;
  logic                  clr_done_q, clr_done_d;

  logic                  oe_s;
  logic                  we_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic                  re_s;
  logic [ADDR_WIDTH-1:0] raddr_s;
  logic                  last_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  assign oe_s = !out_valid_q || out_ready;

  // Next-state, array port control and output-register next values.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    clr_done_d = 1'b0;
    we_s       = 1'b0;
    waddr_s    = mem_addr;
    wdata_s    = mem_wdata;
    re_s       = 1'b0;
    raddr_s    = mem_addr;
    last_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          addr_d  = '0;
        end else if (burst_start) begin
          state_d = ST_BURST;
          addr_d  = burst_addr;
          rem_d   = burst_len;
        end else begin
          // A write does not depend on the output register being free.
          we_s   = mem_wen;
          re_s   = mem_ren && oe_s;
          last_s = 1'b1;
        end
      end
      ST_BURST: begin
        raddr_s = addr_q;
        if (oe_s) begin
          re_s   = 1'b1;
          addr_d = addr_q + ADDR_ONE;
          if (rem_q == '0) begin
            last_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rem_d = rem_q - ADDR_ONE;
          end
        end else begin
          re_s = 1'b0;
        end
      end
      ST_CLEAR: begin
        we_s    = 1'b1;
        waddr_s = addr_q;
        wdata_s = '0;
        addr_d  = addr_q + ADDR_ONE;
        if (addr_q == ADDR_MAX) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_done_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (oe_s) begin
      out_valid_d = re_s;
      out_last_d  = re_s && last_s;
      out_burst_d = re_s && (state_q == ST_BURST);
    end else begin
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_burst_d = out_burst_q;
    end
  end

  // Controller and output-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_burst_q <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_burst_q <= out_burst_d;
      clr_done_q  <= clr_done_d;
    end
  end

  // The array read register doubles as the out_data register.
  sl_preceptron_wram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (we_s),
    .waddr(waddr_s),
    .wdata(wdata_s),
    .re   (re_s),
    .raddr(raddr_s),
    .rdata(rdata_s)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = rdata_s;
  assign busy      = (state_q != ST_IDLE);
  assign acc_ready = (state_q == ST_IDLE) && oe_s;
  // Burst completion coincides with acceptance of the final burst beat.
  assign done      = clr_done_q || (out_valid_q && out_ready && out_last_q && out_burst_q);

endmodule
